key_cond: RTL and testbench



---
 rtl/key_cond.sv | 219 +++++++++++++++++++++
 tb/tb_key_cond.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cond.sv
`default_nettype none
// ============================================================================
// Module   : key_cond
// Purpose  : Key-conditioning stage for the traffic-light controller. Each
//            raw push-button / slide-switch pin is synchronised, normalised
//            to "pressed = 1" and debounced against a shared millisecond
//            timebase. Produces a debounced level plus registered one-cycle
//            press, release and auto-repeat pulses per key.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1       system clock
//   rst_n          in   1       asynchronous active-low reset
//   key_raw_i      in   N_KEYS  asynchronous raw pin levels
//   repeat_en_i    in   N_KEYS  per-key auto-repeat enable (level, clk domain)
//   key_level_o    out  N_KEYS  debounced level, 1 = pressed
//   key_press_o    out  N_KEYS  1-cycle pulse on debounced press
//   key_release_o  out  N_KEYS  1-cycle pulse on debounced release
//   key_repeat_o   out  N_KEYS  1-cycle auto-repeat pulse
//   tick_o         out  1       1-cycle timebase strobe shared by all keys
// ============================================================================
module key_cond #(
  parameter int unsigned N_KEYS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned TICK_DIV   = 12000,
  parameter int unsigned DB_MS      = 20,
  parameter int unsigned LONG_MS    = 800,
  parameter int unsigned REP_MS     = 150
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw_i,
  input  logic [N_KEYS-1:0] repeat_en_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o,
  output logic [N_KEYS-1:0] key_repeat_o,
  output logic              tick_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_cnt_max =
      (DB_MS > LONG_MS) ? ((DB_MS   > REP_MS) ? DB_MS   : REP_MS)
                        : ((LONG_MS > REP_MS) ? LONG_MS : REP_MS);
  localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int unsigned c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [c_presc_w-1:0] c_tick_last = c_presc_w'(TICK_DIV - 1);
  // "Reaches K" = a tick arrives while the counter holds K-1.
  localparam logic [c_cnt_w-1:0]   c_db_last   = c_cnt_w'(DB_MS - 1);
  localparam logic [c_cnt_w-1:0]   c_long_last = c_cnt_w'(LONG_MS - 1);
  localparam logic [c_cnt_w-1:0]   c_long      = c_cnt_w'(LONG_MS);
  localparam logic [c_cnt_w-1:0]   c_rep_last  = c_cnt_w'(REP_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRESS_DB   = 3'd1,
    S_HELD       = 3'd2,
    S_LONG       = 3'd3,
    S_RELEASE_DB = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Shared timebase
  // --------------------------------------------------------------------------
  logic [c_presc_w-1:0] presc_q;
  logic [c_presc_w-1:0] presc_d;
  logic                 w_tick;

  assign w_tick = (presc_q == c_tick_last);

  always_comb begin
    presc_d = presc_q + c_presc_w'(1);
    if (w_tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = w_tick;

  // --------------------------------------------------------------------------
  // Per-key channels
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [1:0]         sync_q;
    logic               w_p;
    state_t             state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               level_q;
    logic               press_q;
    logic               release_q;
    logic               repeat_q;

    // Synchroniser starts at the unpressed pin level so a key already held
    // at reset release is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {2{ACTIVE_LOW}};
      end else begin
        sync_q <= {sync_q[0], key_raw_i[k]};
      end
    end

    assign w_p = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (w_p) begin
              state_q <= S_PRESS_DB;
              cnt_q   <= '0;
            end
          end

          S_PRESS_DB: begin
            if (!w_p) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (w_tick) begin
              if (cnt_q == c_db_last) begin
                state_q <= S_HELD;
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + c_cnt_w'(1);
              end
            end
          end

          S_HELD: begin
            // cnt saturates at LONG_MS so enabling repeat late on a long
            // hold still fires the first repeat straight away.
            if (!w_p) begin
              state_q <= S_RELEASE_DB;
              cnt_q   <= '0;
            end else if (repeat_en_i[k] &&
                         ((cnt_q == c_long) ||
                          (w_tick && (cnt_q == c_long_last)))) begin
              state_q  <= S_LONG;
              cnt_q    <= '0;
              repeat_q <= 1'b1;
            end else if (w_tick && (cnt_q != c_long)) begin
              cnt_q <= cnt_q + c_cnt_w'(1);
            end
          end

          S_LONG: begin
            if (!w_p) begin
              state_q <= S_RELEASE_DB;
              cnt_q   <= '0;
            end else if (w_tick) begin
              if (cnt_q == c_rep_last) begin
                // Repeat disabled: park one tick short of the interval.
                if (repeat_en_i[k]) begin
                  cnt_q    <= '0;
                  repeat_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + c_cnt_w'(1);
              end
            end
          end

          S_RELEASE_DB: begin
            // A short release glitch returns to HELD and restarts the
            // long-press timer rather than resuming it.
            if (w_p) begin
              state_q <= S_HELD;
              cnt_q   <= '0;
            end else if (w_tick) begin
              if (cnt_q == c_db_last) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                release_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + c_cnt_w'(1);
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign key_level_o[k]   = level_q;
    assign key_press_o[k]   = press_q;
    assign key_release_o[k] = release_q;
    assign key_repeat_o[k]  = repeat_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_cond
// Purpose  : Directed self-checking bench for key_cond. Stimulus steps push
//            expected pulse events (kind, key, cycle window) onto a queue; a
//            monitor pops and compares each pulse the DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_cond;

  localparam int N = 4;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_raw;
  logic [N-1:0] repeat_en;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_repeat;
  logic         tick;

  key_cond #(
    .N_KEYS     (N),
    .ACTIVE_LOW (1'b1),
    .TICK_DIV   (4),
    .DB_MS      (3),
    .LONG_MS    (10),
    .REP_MS     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_raw_i     (key_raw),
    .repeat_en_i   (repeat_en),
    .key_level_o   (key_level),
    .key_press_o   (key_press),
    .key_release_o (key_release),
    .key_repeat_o  (key_repeat),
    .tick_o        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected event: absolute window, or window relative to the previous event
  typedef struct {
    int     kind;
    int     key;
    bit     rel;
    longint lo;
    longint hi;
  } exp_t;

  exp_t   sb[$];
  longint cyc      = 0;
  longint last_cyc = 0;
  int     errors   = 0;
  int     checks   = 0;
  logic [2:0] mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int t);
    case (t)
      K_PRESS: return "press";
      K_REL:   return "release";
      default: return "repeat";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_ev(input int kind, input int key, input bit rel,
                         input longint lo, input longint hi);
    exp_t e;
    e.kind = kind;
    e.key  = key;
    e.rel  = rel;
    e.lo   = rel ? lo : cyc + lo;
    e.hi   = rel ? hi : cyc + hi;
    sb.push_back(e);
  endtask

  task automatic check_event(input int k, input int t);
    exp_t   e;
    longint lo;
    longint hi;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_unexpected: observed %s key%0d at cycle %0d, required no pulse",
             kname(t), k, cyc);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      lo = e.rel ? last_cyc + e.lo : e.lo;
      hi = e.rel ? last_cyc + e.hi : e.hi;
      checks++;
      assert (k === e.key && t === e.kind) else begin
        errors++;
        $error("FAIL sb_kind: observed %s key%0d, required %s key%0d",
               kname(t), k, kname(e.kind), e.key);
      end
      checks++;
      assert (cyc >= lo && cyc <= hi) else begin
        errors++;
        $error("FAIL sb_time: %s key%0d observed at cycle %0d, required %0d..%0d",
               kname(t), k, cyc, lo, hi);
      end
    end
    last_cyc = cyc;
  endtask

  // Pulse monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      mon_ev = {key_repeat[k], key_release[k], key_press[k]};
      if (mon_ev != 3'b000) begin
        checks++;
        assert ($countones(mon_ev) == 1) else begin
          errors++;
          $error("FAIL excl key%0d: observed pulses %b, required one-hot", k, mon_ev);
        end
        for (int t = 0; t < 3; t++) begin
          if (mon_ev[t]) check_event(k, t);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int tcount;
    rst_n     = 1'b0;
    key_raw   = 4'hF;
    repeat_en = 4'h0;
    wait_cyc(3);

    // Reset state
    chk("rst_level",  key_level, 0);
    chk("rst_pulses", {key_press, key_release, key_repeat}, 0);
    chk("rst_tick",   tick, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Timebase: one tick every 4 cycles
    tcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) tcount++;
    end
    chk("tick_rate", tcount, 10);

    // Clean press / release on key 0
    key_raw[0] = 1'b0;
    push_ev(K_PRESS, 0, 1'b0, 10, 16);
    wait_cyc(40);
    chk("s1_level_held", key_level[0], 1);
    key_raw[0] = 1'b1;
    push_ev(K_REL, 0, 1'b0, 10, 16);
    wait_cyc(8);
    chk("s1_level_rel_db", key_level[0], 1);
    wait_cyc(22);
    chk("s1_level_rel", key_level[0], 0);
    chk("s1_queue", sb.size(), 0);

    // Bounce rejection on key 1
    for (int i = 0; i < 4; i++) begin
      key_raw[1] = 1'b0;
      wait_cyc(5);
      chk("s2_level_bounce", key_level[1], 0);
      key_raw[1] = 1'b1;
      wait_cyc(3);
    end
    wait_cyc(30);
    chk("s2_level_end", key_level[1], 0);
    chk("s2_queue", sb.size(), 0);

    // Auto-repeat on key 2: press, repeat +40, then every 16 cycles
    repeat_en[2] = 1'b1;
    key_raw[2]   = 1'b0;
    push_ev(K_PRESS, 2, 1'b0, 10, 16);
    push_ev(K_REP,   2, 1'b1, 40, 40);
    for (int i = 0; i < 4; i++) push_ev(K_REP, 2, 1'b1, 16, 16);
    wait_cyc(120);
    key_raw[2] = 1'b1;
    push_ev(K_REL, 2, 1'b0, 10, 16);
    wait_cyc(30);
    chk("s3_level", key_level[2], 0);
    chk("s3_queue", sb.size(), 0);

    // Repeat disabled: press and release only
    repeat_en[2] = 1'b0;
    key_raw[2]   = 1'b0;
    push_ev(K_PRESS, 2, 1'b0, 10, 16);
    wait_cyc(120);
    chk("s4_level_held", key_level[2], 1);
    key_raw[2] = 1'b1;
    push_ev(K_REL, 2, 1'b0, 10, 16);
    wait_cyc(30);
    chk("s4_queue", sb.size(), 0);

    // One-cycle release glitch while held restarts the long-press timer
    repeat_en[2] = 1'b1;
    key_raw[2]   = 1'b0;
    push_ev(K_PRESS, 2, 1'b0, 10, 16);
    wait_cyc(20);
    chk("s5_level_pre", key_level[2], 1);
    push_ev(K_REP, 2, 1'b0, 41, 44);
    key_raw[2] = 1'b1;
    wait_cyc(1);
    key_raw[2] = 1'b0;
    wait_cyc(49);
    chk("s5_level_post", key_level[2], 1);
    key_raw[2] = 1'b1;
    push_ev(K_REL, 2, 1'b0, 10, 16);
    wait_cyc(30);
    chk("s5_queue", sb.size(), 0);

    // Reset during PRESS_DB, key still held afterwards
    key_raw[0] = 1'b0;
    wait_cyc(6);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_level",  key_level, 0);
    chk("s6_rst_pulses", {key_press, key_release, key_repeat}, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    push_ev(K_PRESS, 0, 1'b0, 10, 16);
    wait_cyc(25);
    chk("s6_level_held", key_level[0], 1);
    key_raw[0] = 1'b1;
    push_ev(K_REL, 0, 1'b0, 10, 16);
    wait_cyc(30);
    chk("s6_queue", sb.size(), 0);

    // Reset during LONG
    repeat_en[2] = 1'b1;
    key_raw[2]   = 1'b0;
    push_ev(K_PRESS, 2, 1'b0, 10, 16);
    push_ev(K_REP,   2, 1'b1, 40, 40);
    wait_cyc(62);
    chk("s7_level_long", key_level[2], 1);
    rst_n = 1'b0;
    #1;
    chk("s7_rst_level",  key_level, 0);
    chk("s7_rst_pulses", {key_press, key_release, key_repeat}, 0);
    chk("s7_rst_tick",   tick, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    push_ev(K_PRESS, 2, 1'b0, 10, 16);
    wait_cyc(25);
    key_raw[2] = 1'b1;
    push_ev(K_REL, 2, 1'b0, 10, 16);
    wait_cyc(30);
    chk("s7_queue", sb.size(), 0);

    // Simultaneous press/release on keys 0 and 3 pulse in the same cycle
    repeat_en = 4'h0;
    key_raw   = 4'b0110;
    push_ev(K_PRESS, 0, 1'b0, 10, 16);
    push_ev(K_PRESS, 3, 1'b1, 0, 0);
    wait_cyc(30);
    chk("s8_level_held", key_level, 4'b1001);
    key_raw = 4'hF;
    push_ev(K_REL, 0, 1'b0, 10, 16);
    push_ev(K_REL, 3, 1'b1, 0, 0);
    wait_cyc(30);
    chk("s8_level_rel", key_level, 0);
    chk("s8_queue", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
